core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_pkg.sv | 24 ++
 rtl/reg_bank.sv | 51 +++++
 rtl/core_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and
// default parameter values used by the top level and the register banks.
package core_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_COUNT_DEF = 32;
    localparam int SRC_PORTS_DEF = 3;
    localparam int RESET_PC_DEF  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // True for the states in which the sequencer is waiting on an external handshake.
    function automatic logic is_handshake_state(state_e st);
        return (st == ST_FETCH) || (st == ST_EXEC);
    endfunction

endpackage

// File: rtl/reg_bank.sv
// Multi-read, single-write register bank. Reads are combinational; the write
// lands on the rising edge. With ZERO_R0 set, entry 0 is hardwired to zero.
module reg_bank
    import core_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int SRC_PORTS = SRC_PORTS_DEF,
    parameter bit ZERO_R0   = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst_ni,
    input  logic                                   wr_en_i,
    input  logic [$clog2(REG_COUNT)-1:0]           wr_idx_i,
    input  logic [XLEN-1:0]                        wr_data_i,
    input  logic [SRC_PORTS*$clog2(REG_COUNT)-1:0] rd_idx_i,
    output logic [SRC_PORTS*XLEN-1:0]              rd_data_o
);

    localparam int IDX_W = $clog2(REG_COUNT);

    logic [XLEN-1:0] regs_q [REG_COUNT];
    logic            wr_blocked;

    // A write to entry 0 of a zero-register bank is discarded.
    assign wr_blocked = ZERO_R0 && (wr_idx_i == '0);

    // Register storage: cleared by reset, one write port.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && !wr_blocked) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read ports: plain array reads, no bypass from the write port.
    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < SRC_PORTS; p++) begin
            if (ZERO_R0 && (rd_idx_i[p*IDX_W +: IDX_W] == '0)) begin
                rd_data_o[p*XLEN +: XLEN] = '0;
            end else begin
                rd_data_o[p*XLEN +: XLEN] = regs_q[rd_idx_i[p*IDX_W +: IDX_W]];
            end
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: walks each instruction through fetch, decode,
// execute and writeback using handshakes with an external memory/decoder/ALU,
// owns the general and float register banks, and supports halt, single-step
// and trap-to-halt with resume.
module core_sequencer
    import core_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter int               REG_COUNT = REG_COUNT_DEF,
    parameter int               SRC_PORTS = SRC_PORTS_DEF,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(RESET_PC_DEF)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic                                   fetch_req,
    input  logic                                   fetch_done,
    input  logic [XLEN-1:0]                        instruction,
    output logic [XLEN-1:0]                        pc,
    output logic [XLEN-1:0]                        ir,
    input  logic [SRC_PORTS*$clog2(REG_COUNT)-1:0] dec_src,
    input  logic [$clog2(REG_COUNT)-1:0]           dec_dst,
    input  logic                                   dec_wr_gen,
    input  logic                                   dec_wr_flt,
    output logic                                   exec_req,
    input  logic                                   exec_done,
    input  logic                                   exec_trap,
    input  logic [XLEN-1:0]                        exec_result,
    input  logic [XLEN-1:0]                        exec_next_pc,
    output logic [SRC_PORTS*XLEN-1:0]              gen_src,
    output logic [SRC_PORTS*XLEN-1:0]              flt_src,
    input  logic                                   halt_req,
    input  logic                                   step_en,
    input  logic                                   resume,
    output logic                                   halted,
    output logic                                   trapped,
    output logic [XLEN-1:0]                        trap_pc,
    output logic [XLEN-1:0]                        retired
);

    localparam int              IDX_W      = $clog2(REG_COUNT);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Control state
    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   ir_q;
    logic              trapped_q;
    logic [XLEN-1:0]   trap_pc_q;
    logic [XLEN-1:0]   retired_q;
    logic              fetch_req_q;
    logic              exec_req_q;
    logic              halted_q;

    // Decoded fields and execution results held for later stages
    logic [SRC_PORTS*IDX_W-1:0] src_q;
    logic [IDX_W-1:0]           dst_q;
    logic                       wr_gen_q;
    logic                       wr_flt_q;
    logic [XLEN-1:0]            result_q;
    logic [XLEN-1:0]            next_pc_q;

    // Values committed when leaving WB
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] retired_d;
    logic            stop_d;
    logic            gen_we;
    logic            flt_we;
    logic            in_handshake;

    assign pc_d      = next_pc_q & ALIGN_MASK;
    assign retired_d = retired_q + XLEN'(1);
    assign stop_d    = halt_req || step_en;

    // Bank writes happen only during the single WB cycle.
    assign gen_we = (state_q == ST_WB) && wr_gen_q && (dst_q != '0);
    assign flt_we = (state_q == ST_WB) && wr_flt_q;

    // Handshake requests are registered copies of the state; kept for readability in waves.
    assign in_handshake = is_handshake_state(state_q);

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            trapped_q   <= 1'b0;
            trap_pc_q   <= '0;
            retired_q   <= '0;
            fetch_req_q <= 1'b0;
            exec_req_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_FETCH;
                    fetch_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (fetch_done) begin
                        ir_q        <= instruction;
                        fetch_req_q <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    exec_req_q <= 1'b1;
                    state_q    <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        exec_req_q <= 1'b0;
                        if (exec_trap) begin
                            // Faulting instruction: park in HALT with the PC of the fault.
                            trap_pc_q <= pc_q;
                            trapped_q <= 1'b1;
                            halted_q  <= 1'b1;
                            state_q   <= ST_HALT;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc_q      <= pc_d;
                    retired_q <= retired_d;
                    if (stop_d) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        fetch_req_q <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        trapped_q   <= 1'b0;
                        halted_q    <= 1'b0;
                        fetch_req_q <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end
                default: begin
                    fetch_req_q <= 1'b0;
                    exec_req_q  <= 1'b0;
                    halted_q    <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture decoder fields in DECODE and execution results on a clean exec_done.
    always_ff @(posedge clk) begin
        if (state_q == ST_DECODE) begin
            src_q    <= dec_src;
            dst_q    <= dec_dst;
            wr_gen_q <= dec_wr_gen;
            wr_flt_q <= dec_wr_flt;
        end
        if ((state_q == ST_EXEC) && exec_done && !exec_trap) begin
            result_q  <= exec_result;
            next_pc_q <= exec_next_pc;
        end
    end

    reg_bank #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .SRC_PORTS (SRC_PORTS),
        .ZERO_R0   (1'b1)
    ) u_gen_bank (
        .clk       (clk),
        .rst_ni    (reset),
        .wr_en_i   (gen_we),
        .wr_idx_i  (dst_q),
        .wr_data_i (result_q),
        .rd_idx_i  (src_q),
        .rd_data_o (gen_src)
    );

    reg_bank #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .SRC_PORTS (SRC_PORTS),
        .ZERO_R0   (1'b0)
    ) u_flt_bank (
        .clk       (clk),
        .rst_ni    (reset),
        .wr_en_i   (flt_we),
        .wr_idx_i  (dst_q),
        .wr_data_i (result_q),
        .rd_idx_i  (src_q),
        .rd_data_o (flt_src)
    );

    assign fetch_req = fetch_req_q;
    assign exec_req  = exec_req_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign halted    = halted_q;
    assign trapped   = trapped_q;
    assign trap_pc   = trap_pc_q;
    assign retired   = retired_q;

    // A registered request must never be raised outside its handshake state.
    always_ff @(posedge clk) begin
        if (reset && (fetch_req_q || exec_req_q)) begin
            assert (in_handshake) else $error("request raised outside FETCH/EXEC");
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed table, random instructions against a
// behavioural model, plus trap, single-step, reset-abort and counter-wrap sequences.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_done, exec_req, exec_done, exec_trap;
    logic [31:0] instruction, pc, ir, exec_result, exec_next_pc, trap_pc, retired;
    logic [14:0] dec_src;
    logic [4:0]  dec_dst;
    logic        dec_wr_gen, dec_wr_flt;
    logic [95:0] gen_src, flt_src;
    logic        halt_req, step_en, resume, halted, trapped;

    // narrow instance used for the retired-counter wrap
    logic       fetch_req8, fetch_done8, exec_req8, exec_done8, exec_trap8;
    logic [7:0] instruction8, pc8, ir8, exec_result8, exec_next_pc8, trap_pc8, retired8;
    logic [1:0] dec_src8, dec_dst8;
    logic       dec_wr_gen8, dec_wr_flt8, halt_req8, step_en8, resume8, halted8, trapped8;
    logic [7:0] gen_src8, flt_src8;

    always #5 clk = ~clk;

    core_sequencer dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_done(fetch_done),
        .instruction(instruction), .pc(pc), .ir(ir), .dec_src(dec_src), .dec_dst(dec_dst),
        .dec_wr_gen(dec_wr_gen), .dec_wr_flt(dec_wr_flt), .exec_req(exec_req),
        .exec_done(exec_done), .exec_trap(exec_trap), .exec_result(exec_result),
        .exec_next_pc(exec_next_pc), .gen_src(gen_src), .flt_src(flt_src),
        .halt_req(halt_req), .step_en(step_en), .resume(resume), .halted(halted),
        .trapped(trapped), .trap_pc(trap_pc), .retired(retired)
    );

    core_sequencer #(.XLEN(8), .REG_COUNT(4), .SRC_PORTS(1), .RESET_PC(8'h10)) dut8 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req8), .fetch_done(fetch_done8),
        .instruction(instruction8), .pc(pc8), .ir(ir8), .dec_src(dec_src8), .dec_dst(dec_dst8),
        .dec_wr_gen(dec_wr_gen8), .dec_wr_flt(dec_wr_flt8), .exec_req(exec_req8),
        .exec_done(exec_done8), .exec_trap(exec_trap8), .exec_result(exec_result8),
        .exec_next_pc(exec_next_pc8), .gen_src(gen_src8), .flt_src(flt_src8),
        .halt_req(halt_req8), .step_en(step_en8), .resume(resume8), .halted(halted8),
        .trapped(trapped8), .trap_pc(trap_pc8), .retired(retired8)
    );

    int nvec = 0;
    int nmis = 0;

    // behavioural model of architectural state
    logic [31:0] gm [32];
    logic [31:0] fm [32];
    logic [31:0] pc_m, ret_m, trap_pc_m;
    logic        trapped_m;

    typedef struct {
        logic [14:0] srcs;
        logic [4:0]  dst;
        logic        wg, wf;
        logic [31:0] res, npc;
        logic [31:0] exp_g0, exp_f0, exp_pc, exp_ret;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            gm[i] = 32'h0;
            fm[i] = 32'h0;
        end
        pc_m = 32'h0; ret_m = 32'h0; trap_pc_m = 32'h0; trapped_m = 1'b0;
    endtask

    // One full instruction. Starts while the DUT is in (or heading to) FETCH.
    task automatic do_instr(input logic [14:0] srcs, input logic [4:0] dst, input logic wg,
                            input logic wf, input logic [31:0] res, input logic [31:0] npc,
                            input logic tr, input logic [31:0] ins, input int fwait,
                            input int ewait, output logic [95:0] gs, output logic [95:0] fs);
        int k;
        k = 0;
        while (!fetch_req && k < 20) begin
            tick();
            k++;
        end
        chk("fetch_req_wait", 32'(fetch_req), 32'd1);
        chk("fetch_pc", pc, pc_m);
        for (int w = 0; w < fwait; w++) begin
            exec_done = 1'b1; resume = 1'b1; exec_result = 32'hBAD0BAD0;
            tick();
            chk("fetch_hold", {29'd0, fetch_req, exec_req, halted}, 32'b100);
        end
        exec_done = 1'b0; resume = 1'b0;
        instruction = ins; fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0; instruction = $urandom;
        chk("ir", ir, ins);
        chk("decode_reqs", {30'd0, fetch_req, exec_req}, 32'd0);
        dec_src = srcs; dec_dst = dst; dec_wr_gen = wg; dec_wr_flt = wf;
        tick();
        dec_src = 15'($urandom); dec_dst = 5'($urandom);
        dec_wr_gen = 1'($urandom); dec_wr_flt = 1'($urandom);
        chk("exec_req", {30'd0, exec_req, fetch_req}, 32'b10);
        gs = gen_src; fs = flt_src;
        for (int w = 0; w < ewait; w++) begin
            fetch_done = 1'b1;
            tick();
            chk("exec_hold", {30'd0, exec_req, fetch_req}, 32'b10);
        end
        fetch_done = 1'b0;
        exec_result = res; exec_next_pc = npc; exec_trap = tr; exec_done = 1'b1;
        tick();
        exec_done = 1'b0; exec_trap = 1'b0; exec_result = $urandom; exec_next_pc = $urandom;
        if (tr) begin
            trap_pc_m = pc_m; trapped_m = 1'b1;
            chk("trap_halted", {31'd0, halted}, 32'd1);
            chk("trap_trapped", {31'd0, trapped}, 32'd1);
            chk("trap_pc", trap_pc, trap_pc_m);
            chk("trap_retired", retired, ret_m);
            chk("trap_pc_kept", pc, pc_m);
        end else begin
            chk("wb_outs", {29'd0, fetch_req, exec_req, halted}, 32'd0);
            tick();
            if (wg && dst != 5'd0) gm[dst] = res;
            if (wf) fm[dst] = res;
            pc_m = {npc[31:2], 2'b00};
            ret_m = ret_m + 32'd1;
            chk("wb_pc", pc, pc_m);
            chk("wb_retired", retired, ret_m);
            chk("wb_halted", {31'd0, halted}, {31'd0, halt_req | step_en});
            chk("wb_fetch_req", {31'd0, fetch_req}, {31'd0, ~(halt_req | step_en)});
        end
    endtask

    task automatic do_resume(input int hold);
        for (int w = 0; w < hold; w++) begin
            tick();
            chk("halt_hold", {31'd0, halted}, 32'd1);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        trapped_m = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_trapped", {31'd0, trapped}, 32'd0);
        chk("resume_fetch", {31'd0, fetch_req}, 32'd1);
        chk("resume_pc", pc, pc_m);
    endtask

    task automatic step8(input logic [7:0] npc);
        int k;
        k = 0;
        while (!fetch_req8 && k < 20) begin
            tick();
            k++;
        end
        chk("w8_fetch_wait", {31'd0, fetch_req8}, 32'd1);
        fetch_done8 = 1'b1;
        tick();
        fetch_done8 = 1'b0;
        tick();
        exec_done8 = 1'b1; exec_next_pc8 = npc;
        tick();
        exec_done8 = 1'b0;
        tick();
    endtask

    logic [95:0] gs, fs;
    logic [4:0]  s;
    logic [31:0] ret_before;
    logic        tr, wg, wf, stop;
    int          halts;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{15'd0,  5'd5,  1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0007, 32'h0,          32'h0,  32'h4,  32'd1};
        tbl[1] = '{15'd5,  5'd0,  1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0040, 32'hDEAD_BEEF,  32'h0,  32'h40, 32'd2};
        tbl[2] = '{15'd0,  5'd1,  1'b0, 1'b1, 32'h0000_0055, 32'h0000_0040, 32'h0,          32'hFF, 32'h40, 32'd3};
        tbl[3] = '{15'd1,  5'd31, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0000_0043, 32'h0,          32'h55, 32'h40, 32'd4};
        tbl[4] = '{15'd31, 5'd31, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_0040, 32'hA5A5_A5A5,  32'h0,  32'h40, 32'd5};

        reset = 1'b0;
        fetch_done = 0; exec_done = 0; exec_trap = 0; instruction = 0;
        exec_result = 0; exec_next_pc = 0; dec_src = 0; dec_dst = 0;
        dec_wr_gen = 0; dec_wr_flt = 0; halt_req = 0; step_en = 0; resume = 0;
        fetch_done8 = 0; exec_done8 = 0; exec_trap8 = 0; instruction8 = 8'h5A;
        exec_result8 = 8'h77; exec_next_pc8 = 0; dec_src8 = 0; dec_dst8 = 2'd1;
        dec_wr_gen8 = 1; dec_wr_flt8 = 1; halt_req8 = 0; step_en8 = 0; resume8 = 0;
        model_reset();

        #12;
        chk("rst_reqs", {28'd0, fetch_req, exec_req, halted, trapped}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_trap_pc", trap_pc, 32'h0);
        chk("rst_pc8", {24'd0, pc8}, 32'h10);
        reset = 1'b1;
        tick();

        // directed table; first fetch_done arrives on the third FETCH cycle
        for (int i = 0; i < 5; i++) begin
            do_instr(tbl[i].srcs, tbl[i].dst, tbl[i].wg, tbl[i].wf, tbl[i].res, tbl[i].npc,
                     1'b0, (i == 0) ? 32'h1234_5678 : 32'(i), (i == 0) ? 2 : i % 2, i % 3, gs, fs);
            chk("tbl_gen_rd", gs[31:0], tbl[i].exp_g0);
            chk("tbl_flt_rd", fs[31:0], tbl[i].exp_f0);
            chk("tbl_pc", pc, tbl[i].exp_pc);
            chk("tbl_retired", retired, tbl[i].exp_ret);
        end

        // trap at pc 0x40 then resume
        do_instr(15'd0, 5'd2, 1'b1, 1'b1, 32'hCAFE_0000, 32'h0000_0100, 1'b1, 32'h0BAD, 1, 1, gs, fs);
        chk("trap_pc_40", trap_pc, 32'h40);
        chk("trap_ret_5", retired, 32'd5);
        do_resume(2);
        chk("resume_pc_40", pc, 32'h40);
        // the trapped instruction must not have written
        do_instr({5'd0, 5'd0, 5'd2}, 5'd0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h1, 0, 0, gs, fs);
        chk("trap_no_wb_gen", gs[31:0], 32'h0);
        chk("trap_no_wb_flt", fs[31:0], 32'h0);

        // random instructions against the model
        for (int n = 0; n < 120; n++) begin
            tr = ($urandom_range(0, 9) == 0);
            wg = 1'($urandom); wf = 1'($urandom);
            halt_req = ($urandom_range(0, 5) == 0);
            dec_src = 15'($urandom);
            do_instr(15'($urandom), 5'($urandom), wg, wf, $urandom, $urandom, tr, $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 2), gs, fs);
            for (int p = 0; p < 3; p++) begin
                s = dec_src[p*5 +: 5];
            end
            stop = tr | halt_req;
            halt_req = 1'b0;
            if (stop) do_resume($urandom_range(0, 2));
        end

        // random read-back of every register through all three ports
        for (int r = 0; r < 32; r += 3) begin
            do_instr({5'(r + 2), 5'(r + 1), 5'(r)}, 5'd0, 1'b0, 1'b0, 32'h0, pc_m, 1'b0, 32'h2, 0, 0, gs, fs);
            for (int p = 0; p < 3; p++) begin
                s = 5'(r + p);
                chk("rand_gen_rd", gs[p*32 +: 32], (s == 5'd0) ? 32'h0 : gm[s]);
                chk("rand_flt_rd", fs[p*32 +: 32], fm[s]);
            end
        end

        // single-step over three instructions
        step_en = 1'b1; halts = 0; ret_before = ret_m;
        for (int n = 0; n < 3; n++) begin
            do_instr(15'd0, 5'd3, 1'b1, 1'b0, 32'(n), 32'h80, 1'b0, 32'h3, 0, 1, gs, fs);
            if (halted) halts++;
            do_resume(1);
        end
        step_en = 1'b0;
        chk("step_halts", 32'(halts), 32'd3);
        chk("step_retired", retired - ret_before, 32'd3);

        // reset asserted in the middle of EXEC
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        tick();
        chk("pre_rst_exec", {31'd0, exec_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_reqs", {28'd0, fetch_req, exec_req, halted, trapped}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_ir", ir, 32'h0);
        chk("arst_retired", retired, 32'h0);
        chk("arst_trap_pc", trap_pc, 32'h0);
        tick();
        exec_done = 1'b1; exec_result = 32'hFFFF_FFFF; exec_next_pc = 32'h100;
        #3 reset = 1'b1;
        tick();
        exec_done = 1'b0;
        model_reset();
        chk("post_rst_fetch", {30'd0, fetch_req, exec_req}, 32'b10);
        chk("post_rst_retired", retired, 32'h0);
        do_instr({5'd1, 5'd5, 5'd31}, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 0, 0, gs, fs);
        chk("post_rst_r31", gs[31:0], 32'h0);
        chk("post_rst_r5", gs[63:32], 32'h0);
        chk("post_rst_f1", fs[95:64], 32'h0);

        // retired counter wrap on the narrow instance
        for (int n = 0; n < 255; n++) step8(8'h23);
        chk("w8_retired_max", {24'd0, retired8}, 32'hFF);
        chk("w8_pc", {24'd0, pc8}, 32'h20);
        step8(8'h23);
        chk("w8_retired_wrap", {24'd0, retired8}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
